// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: the FSM state
// encoding and the width of one adder slice.
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_adder.sv
// Existing 4-bit carry-lookahead adder slice. Its carries are formed from the
// generate/propagate terms rather than rippled from bit to bit.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products over the lower bit positions.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands by stepping one 4-bit CLA slice across them,
// least-significant nibble first, holding each nibble STEP_CYC cycles.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STEP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBS    = WIDTH / NIB_W;
  localparam int NIB_CW  = $clog2(NIBS);
  localparam int STEP_CW = $clog2(STEP_CYC + 1);

  localparam logic [NIB_CW-1:0]  NIB_LAST  = NIB_CW'(NIBS - 1);
  localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_CYC - 1);

  // Handshake: start is honoured only in IDLE (busy=0, done=0); busy stays high
  // for the whole RUN phase and done pulses for exactly one cycle afterwards.
  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic               a_msb;
  logic               b_msb;
  logic [NIB_CW-1:0]  nib_cnt;
  logic [STEP_CW-1:0] step_cnt;

  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;
  logic               capture;
  logic               last_nib;
  logic [WIDTH-1:0]   res_next;

  cla_adder u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign capture  = (state == S_RUN) && (step_cnt == STEP_LAST);
  assign last_nib = (nib_cnt == NIB_LAST);
  // New nibble enters at the top so the LS nibble ends up at bit 0.
  assign res_next = {slice_sum, res[WIDTH-1:NIB_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (capture && last_nib) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      nib_cnt  <= '0;
      step_cnt <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            nib_cnt  <= '0;
            step_cnt <= '0;
          end
        end
        S_RUN: begin
          if (capture) begin
            res      <= res_next;
            a_sh     <= {{NIB_W{1'b0}}, a_sh[WIDTH-1:NIB_W]};
            b_sh     <= {{NIB_W{1'b0}}, b_sh[WIDTH-1:NIB_W]};
            carry    <= slice_cout;
            step_cnt <= '0;
            nib_cnt  <= nib_cnt + 1'b1;
            if (last_nib) begin
              sum  <= res_next;
              cout <= slice_cout;
              // Overflow: like-signed operands produced a result of the other sign.
              ovf  <= (a_msb == b_msb) && (slice_sum[NIB_W-1] != a_msb);
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
